// File: rtl/egg_timer_sequencer.sv
// Egg-timer controller: key edge detection, per-field time entry, borrow-chained
// countdown on the 1 Hz tick, pause/resume and a tick-paced, bounded alarm flash.
module egg_timer_sequencer #(
   parameter int NUM_FIELDS  = 2,
   parameter int FIELD_W     = 6,
   parameter int FIELD_MAX   = 59,
   parameter int FLASH_TICKS = 10,
   parameter int SEL_W       = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tick,
   input  logic                          key_clear,
   input  logic                          key_set,
   input  logic                          key_inc,
   input  logic                          key_start,
   output logic [2:0]                    state,
   output logic [SEL_W-1:0]              field_sel,
   output logic [NUM_FIELDS*FIELD_W-1:0] time_val,
   output logic                          alarm,
   output logic                          done
);

   localparam int                 CNT_W      = $clog2(FLASH_TICKS + 1);
   localparam int                 TW         = NUM_FIELDS * FIELD_W;
   localparam logic [FIELD_W-1:0] L_MAX      = FIELD_W'(FIELD_MAX);
   localparam logic [SEL_W-1:0]   L_LAST     = SEL_W'(NUM_FIELDS - 1);
   localparam logic [CNT_W-1:0]   L_CNT_LAST = CNT_W'(FLASH_TICKS - 1);

   typedef enum logic [2:0] {
      ST_SET       = 3'b000,
      ST_UNUSED    = 3'b001,
      ST_RUN       = 3'b010,
      ST_READY     = 3'b011,
      ST_IDLE      = 3'b100,
      ST_FLASH_ON  = 3'b101,
      ST_FLASH_OFF = 3'b110,
      ST_PAUSE     = 3'b111
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [SEL_W-1:0]   r_field_sel, w_sel_nxt;
   logic [TW-1:0]      r_time, w_time_nxt, w_time_inc, w_time_dec;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_alarm, r_done, w_done_nxt;
   logic               r_set_q, r_inc_q, r_start_q;
   logic               w_set_rise, w_inc_rise, w_start_rise, w_any_rise;
   logic               w_borrow, w_dec_zero;

   assign w_set_rise   = key_set & ~r_set_q;
   assign w_inc_rise   = key_inc & ~r_inc_q;
   assign w_start_rise = key_start & ~r_start_q;
   assign w_any_rise   = w_set_rise | w_inc_rise | w_start_rise;

   // Selected field +1 with wrap to zero past FIELD_MAX
   always_comb begin
      w_time_inc = r_time;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (SEL_W'(i) == r_field_sel) begin
            if (r_time[i*FIELD_W +: FIELD_W] == L_MAX) begin
               w_time_inc[i*FIELD_W +: FIELD_W] = '0;
            end else begin
               w_time_inc[i*FIELD_W +: FIELD_W] = r_time[i*FIELD_W +: FIELD_W] + FIELD_W'(1);
            end
         end else begin
            w_time_inc[i*FIELD_W +: FIELD_W] = r_time[i*FIELD_W +: FIELD_W];
         end
      end
   end

   // Ripple-borrow decrement: a zero field reloads FIELD_MAX and passes the borrow on
   always_comb begin
      w_time_dec = r_time;
      w_borrow   = 1'b1;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (w_borrow) begin
            if (r_time[i*FIELD_W +: FIELD_W] == '0) begin
               w_time_dec[i*FIELD_W +: FIELD_W] = L_MAX;
            end else begin
               w_time_dec[i*FIELD_W +: FIELD_W] = r_time[i*FIELD_W +: FIELD_W] - FIELD_W'(1);
               w_borrow = 1'b0;
            end
         end else begin
            w_time_dec[i*FIELD_W +: FIELD_W] = r_time[i*FIELD_W +: FIELD_W];
         end
      end
      w_dec_zero = (w_time_dec == '0);
   end

   // Next-state and datapath update; key_clear overrides every other event
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_field_sel;
      w_time_nxt  = r_time;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      if (key_clear) begin
         w_state_nxt = ST_IDLE;
         w_sel_nxt   = '0;
         w_time_nxt  = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_SET;
               w_sel_nxt   = '0;
            end
            ST_SET: begin
               if (w_inc_rise) begin
                  w_time_nxt = w_time_inc;
               end else begin
                  w_time_nxt = r_time;
               end
               if (w_set_rise) begin
                  if (r_field_sel == L_LAST) begin
                     w_state_nxt = ST_READY;
                     w_sel_nxt   = '0;
                  end else begin
                     w_sel_nxt = r_field_sel + SEL_W'(1);
                  end
               end else begin
                  w_sel_nxt = r_field_sel;
               end
            end
            ST_READY: begin
               if (w_start_rise && (r_time != '0)) begin
                  w_state_nxt = ST_RUN;
               end else if (w_set_rise) begin
                  w_state_nxt = ST_SET;
                  w_sel_nxt   = '0;
               end else begin
                  w_state_nxt = ST_READY;
               end
            end
            ST_RUN: begin
               if (tick) begin
                  w_time_nxt = w_time_dec;
               end else begin
                  w_time_nxt = r_time;
               end
               if (tick && w_dec_zero) begin
                  w_state_nxt = ST_FLASH_ON;
                  w_done_nxt  = 1'b1;
                  w_cnt_nxt   = '0;
               end else if (w_start_rise) begin
                  w_state_nxt = ST_PAUSE;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_PAUSE: begin
               if (w_start_rise) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_PAUSE;
               end
            end
            ST_FLASH_ON, ST_FLASH_OFF: begin
               if (w_any_rise) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else if (tick) begin
                  if (r_cnt == L_CNT_LAST) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_state_nxt = (r_state == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
                     w_cnt_nxt   = r_cnt + CNT_W'(1);
                  end
               end else begin
                  w_state_nxt = r_state;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, datapath, output and key-history registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_field_sel <= '0;
         r_time      <= '0;
         r_cnt       <= '0;
         r_alarm     <= 1'b0;
         r_done      <= 1'b0;
         r_set_q     <= 1'b1;
         r_inc_q     <= 1'b1;
         r_start_q   <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_field_sel <= w_sel_nxt;
         r_time      <= w_time_nxt;
         r_cnt       <= w_cnt_nxt;
         r_alarm     <= (w_state_nxt == ST_FLASH_ON);
         r_done      <= w_done_nxt;
         r_set_q     <= key_set;
         r_inc_q     <= key_inc;
         r_start_q   <= key_start;
      end
   end

   assign state     = r_state;
   assign field_sel = r_field_sel;
   assign time_val  = r_time;
   assign alarm     = r_alarm;
   assign done      = r_done;

endmodule
